// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 16;
  localparam int MEM_LAT_DEF    = 1;
  localparam int MAX_DM_RUN_DEF = 3;

  // Wide enough for the largest legal latency load value (MEM_LAT-1 = 6).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the memory access window; zero marks the
// final cycle of the access.
module arb_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // NOTE: count_d gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory with a
// fixed access latency; data has priority, bounded by a starvation streak limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int MAX_DM_RUN = MAX_DM_RUN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_RUN);
  localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LAT - 1);

  if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..7");
  end

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  mask_q, mask_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;

  logic if_vld, dm_vld, fetch_forced;
  logic grant_if, grant_dm, cnt_zero, last_busy;

  // The requester that just completed sits out exactly one IDLE cycle.
  assign if_vld       = if_req && !(mask_q && (owner_q == OWN_IF));
  assign dm_vld       = dm_req && !(mask_q && (owner_q == OWN_DM));
  assign fetch_forced = if_vld && (streak_q == STREAK_MAX);
  assign grant_dm     = (state_q == IDLE) && dm_vld && !fetch_forced;
  assign grant_if     = (state_q == IDLE) && if_vld && !grant_dm;
  assign last_busy    = (state_q == BUSY) && cnt_zero;

  arb_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (grant_if || grant_dm),
    .load_val (LAT_LOAD),
    .dec      (state_q == BUSY),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_if || grant_dm) state_d = BUSY;
      BUSY:    if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, starvation streak and read-data capture.
  always_comb begin
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mask_d     = (state_q == DONE);
    if (grant_dm) begin
      owner_d = OWN_DM;
      addr_d  = dm_addr;
      we_d    = dm_we;
      wdata_d = dm_wdata;
      if (if_req && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (grant_if) begin
      owner_d  = OWN_IF;
      addr_d   = if_addr;
      we_d     = 1'b0;
      streak_d = '0;
    end
    if (last_busy && !we_q) begin
      if (owner_q == OWN_DM) begin
        dm_rdata_d = mem_rdata;
      end else begin
        if_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      streak_q   <= '0;
      mask_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      mask_q     <= mask_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    mem_en    = (state_q == BUSY);
    mem_rw    = (state_q == BUSY) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_done   = (state_q == DONE) && (owner_q == OWN_IF);
    dm_done   = (state_q == DONE) && (owner_q == OWN_DM);
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on a MEM_LAT=1 and a MEM_LAT=3
// instance, then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW     = 12;
  localparam int DW     = 16;
  localparam int MAXRUN = 3;

  logic clk;
  logic reset;
  logic [1:0]         if_req, dm_req, dm_we, if_done, dm_done, mem_en, mem_rw;
  logic [1:0][AW-1:0] if_addr, dm_addr, mem_addr;
  logic [1:0][DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per instance, remaining busy cycles, a pending done, the
  // latched transaction, the held read data, the masked requester and the streak.
  int              m_busy[2];
  bit              m_done[2];
  bit              m_own_dm[2];
  bit              m_we[2];
  logic [AW-1:0]   m_addr[2];
  logic [DW-1:0]   m_wdata[2];
  logic [DW-1:0]   m_if_rd[2];
  logic [DW-1:0]   m_dm_rd[2];
  int              m_mask[2];
  int              m_streak[2];

  function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
    if (a == 12'h010) return 16'hBEEF;
    return {a[3:0], a} ^ 16'h3C5A;
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .MEM_LAT    ((g == 0) ? 1 : 3),
      .MAX_DM_RUN (MAXRUN)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_done   (if_done[g]),
      .if_rdata  (if_rdata[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_done   (dm_done[g]),
      .dm_rdata  (dm_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_rw    (mem_rw[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
    assign mem_rdata[g] = mem_fn(mem_addr[g]);
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;   m_done[d] = 1'b0; m_own_dm[d] = 1'b0; m_we[d] = 1'b0;
      m_addr[d] = '0;  m_wdata[d] = '0;  m_if_rd[d] = '0;    m_dm_rd[d] = '0;
      m_mask[d] = -1;  m_streak[d] = 0;
    end
  endtask

  // Advances one instance's model by one clock using the inputs present now.
  task automatic model_step(int d);
    bit e_if, e_dm, pick_dm;
    if (m_busy[d] > 0) begin
      m_busy[d]--;
      m_mask[d] = -1;
      if (m_busy[d] == 0) begin
        m_done[d] = 1'b1;
        if (!m_we[d]) begin
          if (m_own_dm[d]) m_dm_rd[d] = mem_fn(m_addr[d]);
          else             m_if_rd[d] = mem_fn(m_addr[d]);
        end
      end
    end else if (m_done[d]) begin
      m_done[d] = 1'b0;
      m_mask[d] = m_own_dm[d] ? 1 : 0;
    end else begin
      e_if    = if_req[d] && (m_mask[d] != 0);
      e_dm    = dm_req[d] && (m_mask[d] != 1);
      pick_dm = e_dm && !(e_if && (m_streak[d] == MAXRUN));
      m_mask[d] = -1;
      if (pick_dm) begin
        m_busy[d] = lat_of(d); m_own_dm[d] = 1'b1; m_addr[d] = dm_addr[d];
        m_we[d] = dm_we[d];    m_wdata[d] = dm_wdata[d];
        if (if_req[d] && (m_streak[d] < MAXRUN)) m_streak[d]++;
      end else if (e_if) begin
        m_busy[d] = lat_of(d); m_own_dm[d] = 1'b0; m_addr[d] = if_addr[d];
        m_we[d] = 1'b0;        m_streak[d] = 0;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(int d);
    logic en, wr;
    en = (m_busy[d] > 0);
    wr = en && m_we[d];
    return {en, wr, en ? m_addr[d] : AW'(0), wr ? m_wdata[d] : DW'(0),
            m_done[d] && !m_own_dm[d], m_done[d] && m_own_dm[d], m_if_rd[d], m_dm_rd[d]};
  endfunction

  function automatic logic [63:0] obs_vec(int d);
    logic en, wr;
    en = (m_busy[d] > 0);
    wr = en && m_we[d];
    return {mem_en[d], mem_rw[d], en ? mem_addr[d] : AW'(0), wr ? mem_wdata[d] : DW'(0),
            if_done[d], dm_done[d], if_rdata[d], dm_rdata[d]};
  endfunction

  // Inputs are set at the falling edge; this advances to the next falling edge.
  task automatic tick();
    if (reset) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    if_req = '0;
    dm_req = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    if_req = '0;
    dm_req = '0;
    reset  = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) $display("FAIL reset_outputs[%0d]: got %h expected %h", d, obs_vec(d), exp_vec(d));
      else n_pass++;
      n_chk++;
      if ({mem_addr[d], mem_wdata[d]} !== 28'h0) $display("FAIL reset_mem_bus[%0d]: got %h expected 0", d, {mem_addr[d], mem_wdata[d]});
      else n_pass++;
    end
    reset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({mem_en[d], if_done[d], dm_done[d]} !== 3'b000) $display("FAIL idle_after_reset[%0d]: got %b expected 000", d, {mem_en[d], if_done[d], dm_done[d]});
      else n_pass++;
    end
  endtask

  task automatic test_lat1_read();
    idle(2);
    dm_we[0] = 1'b0; dm_addr[0] = 12'h010; dm_req[0] = 1'b1;
    tick();
    n_chk++;
    if ({mem_en[0], mem_rw[0], dm_done[0], mem_addr[0]} !== {3'b100, 12'h010})
      $display("FAIL lat1_busy: got %h expected %h", {mem_en[0], mem_rw[0], dm_done[0], mem_addr[0]}, {3'b100, 12'h010});
    else n_pass++;
    tick();
    n_chk++;
    if ({mem_en[0], dm_done[0], if_done[0], dm_rdata[0]} !== {3'b010, 16'hBEEF})
      $display("FAIL lat1_done: got %h expected %h", {mem_en[0], dm_done[0], if_done[0], dm_rdata[0]}, {3'b010, 16'hBEEF});
    else n_pass++;
    dm_req[0] = 1'b0;
  endtask

  task automatic test_both_req();
    logic [7:0] en_seen, dmd_seen, ifd_seen;
    idle(2);
    en_seen = '0; dmd_seen = '0; ifd_seen = '0;
    dm_we[0] = 1'b0; dm_addr[0] = 12'h155; if_addr[0] = 12'h2A0;
    dm_req[0] = 1'b1; if_req[0] = 1'b1;
    for (int c = 1; c < 8; c++) begin
      tick();
      en_seen[c] = mem_en[0]; dmd_seen[c] = dm_done[0]; ifd_seen[c] = if_done[0];
      if (dm_done[0]) dm_req[0] = 1'b0;
      if (if_done[0]) if_req[0] = 1'b0;
    end
    n_chk++;
    if (en_seen !== 8'b0001_0010) $display("FAIL both_mem_en: got %b expected %b", en_seen, 8'b0001_0010);
    else n_pass++;
    n_chk++;
    if (dmd_seen !== 8'b0000_0100) $display("FAIL both_dm_done: got %b expected %b", dmd_seen, 8'b0000_0100);
    else n_pass++;
    n_chk++;
    if (ifd_seen !== 8'b0010_0000) $display("FAIL both_if_done: got %b expected %b", ifd_seen, 8'b0010_0000);
    else n_pass++;
    n_chk++;
    if ((dmd_seen & ifd_seen) !== 8'h00) $display("FAIL both_done_overlap: got %b expected 0", dmd_seen & ifd_seen);
    else n_pass++;
  endtask

  // Fetch is held low only in the data port's masked cycle, so every data
  // grant happens with fetch waiting; the fourth grant must go to fetch.
  task automatic test_dm_run();
    logic [3:0] order;
    int n_gr;
    bit prev_dm_done;
    do_reset();
    order = '0; n_gr = 0; prev_dm_done = 1'b0;
    dm_we[0] = 1'b0; dm_addr[0] = 12'h040; if_addr[0] = 12'h080;
    dm_req[0] = 1'b1; if_req[0] = 1'b1;
    for (int c = 0; (c < 40) && (n_gr < 4); c++) begin
      tick();
      if (dm_done[0] && (n_gr < 4)) begin order[n_gr] = 1'b1; n_gr++; end
      else if (if_done[0] && (n_gr < 4)) begin order[n_gr] = 1'b0; n_gr++; end
      if_req[0] = !prev_dm_done;
      prev_dm_done = dm_done[0];
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    n_chk++;
    if (n_gr !== 4) $display("FAIL dm_run_count: got %0d expected 4 (cycle budget expired)", n_gr);
    else n_pass++;
    n_chk++;
    if (order !== 4'b0111) $display("FAIL dm_run_order: got %b expected %b (bit0 first, 1=DM)", order, 4'b0111);
    else n_pass++;
  endtask

  task automatic test_lat3_write();
    logic [DW-1:0] prev;
    idle(2);
    prev = m_dm_rd[1];
    dm_we[1] = 1'b1; dm_addr[1] = 12'h0FF; dm_wdata[1] = 16'h1234; dm_req[1] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_chk++;
      if ({mem_en[1], mem_rw[1], dm_done[1], mem_addr[1], mem_wdata[1]} !== {3'b110, 12'h0FF, 16'h1234})
        $display("FAIL lat3_write_busy%0d: got %h expected %h", c,
                 {mem_en[1], mem_rw[1], dm_done[1], mem_addr[1], mem_wdata[1]}, {3'b110, 12'h0FF, 16'h1234});
      else n_pass++;
      dm_addr[1] = AW'($urandom); dm_wdata[1] = DW'($urandom);
    end
    tick();
    n_chk++;
    if ({mem_en[1], dm_done[1], if_done[1], dm_rdata[1]} !== {3'b010, prev})
      $display("FAIL lat3_write_done: got %h expected %h", {mem_en[1], dm_done[1], if_done[1], dm_rdata[1]}, {3'b010, prev});
    else n_pass++;
    dm_req[1] = 1'b0;
  endtask

  task automatic test_reset_busy();
    idle(2);
    dm_we[1] = 1'b0; dm_addr[1] = 12'h321; dm_req[1] = 1'b1;
    tick();
    tick();
    n_chk++;
    if (mem_en[1] !== 1'b1) $display("FAIL rst_busy_pre: got mem_en=%b expected 1", mem_en[1]);
    else n_pass++;
    reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({mem_en[1], mem_rw[1], if_done[1], dm_done[1], mem_addr[1]} !== 16'h0)
      $display("FAIL rst_busy_immediate: got %h expected 0", {mem_en[1], mem_rw[1], if_done[1], dm_done[1], mem_addr[1]});
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if ({mem_en[1], if_done[1], dm_done[1]} !== 3'b000)
        $display("FAIL rst_busy_held%0d: got %b expected 000", c, {mem_en[1], if_done[1], dm_done[1]});
      else n_pass++;
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if ({mem_en[1], mem_addr[1]} !== {1'b1, 12'h321})
      $display("FAIL rst_busy_regrant: got %h expected %h", {mem_en[1], mem_addr[1]}, {1'b1, 12'h321});
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if ({dm_done[1], dm_rdata[1]} !== {1'b1, mem_fn(12'h321)})
      $display("FAIL rst_busy_done: got %h expected %h", {dm_done[1], dm_rdata[1]}, {1'b1, mem_fn(12'h321)});
    else n_pass++;
    dm_req[1] = 1'b0;
  endtask

  task automatic test_if_change();
    idle(2);
    if_addr[1] = 12'h123; if_req[1] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_chk++;
      if ({mem_en[1], if_done[1], mem_addr[1]} !== {2'b10, 12'h123})
        $display("FAIL if_change_busy%0d: got %h expected %h", c, {mem_en[1], if_done[1], mem_addr[1]}, {2'b10, 12'h123});
      else n_pass++;
      if_addr[1] = 12'h456; if_req[1] = 1'b0;
    end
    tick();
    n_chk++;
    if ({if_done[1], dm_done[1], if_rdata[1]} !== {2'b10, mem_fn(12'h123)})
      $display("FAIL if_change_done: got %h expected %h", {if_done[1], dm_done[1], if_rdata[1]}, {2'b10, mem_fn(12'h123)});
    else n_pass++;
  endtask

  task automatic drive_random(int d);
    if (if_done[d]) begin
      if_req[d] = 1'($urandom_range(0, 1)); if_addr[d] = AW'($urandom);
    end else if (!if_req[d]) begin
      if ($urandom_range(0, 3) == 0) begin if_req[d] = 1'b1; if_addr[d] = AW'($urandom); end
    end else if ($urandom_range(0, 15) == 0) begin
      if_addr[d] = AW'($urandom);
    end else if ($urandom_range(0, 31) == 0) begin
      if_req[d] = 1'b0;
    end
    if (dm_done[d] || (!dm_req[d] && ($urandom_range(0, 2) == 0))) begin
      dm_req[d] = dm_done[d] ? 1'($urandom_range(0, 1)) : 1'b1;
      dm_we[d] = 1'($urandom_range(0, 1)); dm_addr[d] = AW'($urandom); dm_wdata[d] = DW'($urandom);
    end else if (dm_req[d] && ($urandom_range(0, 15) == 0)) begin
      dm_addr[d] = AW'($urandom); dm_wdata[d] = DW'($urandom);
    end else if (dm_req[d] && ($urandom_range(0, 31) == 0)) begin
      dm_req[d] = 1'b0;
    end
  endtask

  task automatic test_random();
    idle(2);
    for (int c = 0; c < 400; c++) begin
      drive_random(0);
      drive_random(1);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs_vec(d) !== exp_vec(d))
          $display("FAIL random[%0d] cycle %0d: got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = '0; dm_req = '0; dm_we = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    model_reset();
    #2 reset = 1'b0;
    test_reset();
    test_lat1_read();
    test_both_req();
    test_dm_run();
    test_lat3_write();
    test_reset_busy();
    test_if_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
